fft_peak_detect: RTL and testbench

- Streaming peak-bin detector for complex FFT output frames. Parametrised successor to the single-bin frequency decoder.
- Accepts one complex bin per valid cycle and computes the full-precision squared magnitude through a 2-stage pipeline.
- Tracks the maximum over a configurable bin window, applies a runtime magnitude threshold, and reports bin, magnitude and frequency in Hz once per frame.
- Sits between the FFT core and the note mapper/display logic. Never stalls the FFT.

---
 rtl/fft_pkg.sv | 21 ++
 rtl/fft_mag_sq.sv | 57 +++++
 rtl/fft_peak_detect.sv | 156 +++++++++++++++
 tb/tb_fft_peak_detect.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/fft_pkg.sv
// Shared constants, types and the bin-to-Hz helper for the FFT peak detector.
package fft_pkg;

    localparam int BIT_WIDTH = 16;
    localparam int N         = 9;
    localparam int FFT_SIZE  = 1 << N;
    localparam int FS        = 48000;

    typedef logic [N-1:0]           bin_t;
    typedef logic [2*BIT_WIDTH-1:0] mag_t;

    // Exact product; widths of bin and fs never exceed 32 bits, so 64 cannot overflow.
    function automatic logic [31:0] bin_to_hz(input logic [31:0] bin,
                                              input logic [31:0] fs,
                                              input int          n);
        logic [63:0] prod;
        prod = {32'b0, bin} * {32'b0, fs};
        return 32'(prod >> n);
    endfunction

endpackage

// File: rtl/fft_mag_sq.sv
// Registered squared magnitude of one complex bin; frame tags ride alongside the data.
module fft_mag_sq #(
    parameter int BIT_WIDTH = 16,
    parameter int N         = 9
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   in_first,
    input  logic                   in_last,
    input  logic                   in_err,
    input  logic [N-1:0]           in_k,
    input  logic [2*BIT_WIDTH-1:0] in_data,
    output logic                   out_valid,
    output logic                   out_first,
    output logic                   out_last,
    output logic                   out_err,
    output logic [N-1:0]           out_k,
    output logic [2*BIT_WIDTH-1:0] out_mag
);

    localparam int MW = 2 * BIT_WIDTH;

    logic signed [BIT_WIDTH-1:0] re, im;
    logic signed [MW-1:0]        re_x, im_x, rr, ii;
    logic        [MW-1:0]        mag_d;

    assign re    = in_data[MW-1:BIT_WIDTH];
    assign im    = in_data[BIT_WIDTH-1:0];
    assign re_x  = MW'(re);
    assign im_x  = MW'(im);
    assign rr    = re_x * re_x;
    assign ii    = im_x * im_x;
    // Each square is at most 2**(MW-2), so the sum fits MW bits unsigned.
    assign mag_d = $unsigned(rr) + $unsigned(ii);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid <= 1'b0;
            out_first <= 1'b0;
            out_last  <= 1'b0;
            out_err   <= 1'b0;
            out_k     <= '0;
            out_mag   <= '0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                out_first <= in_first;
                out_last  <= in_last;
                out_err   <= in_err;
                out_k     <= in_k;
                out_mag   <= mag_d;
            end
        end
    end

endmodule

// File: rtl/fft_peak_detect.sv
// Streaming peak-bin detector over FFT frames; reports bin, |X|^2 and Hz once per frame.
// Build option PEAK_STABLE_EN: note_valid also requires a stable peak across good frames.
module fft_peak_detect
    import fft_pkg::bin_to_hz;
#(
    parameter int BIT_WIDTH = fft_pkg::BIT_WIDTH,
    parameter int N         = fft_pkg::N,
    parameter int FFT_SIZE  = fft_pkg::FFT_SIZE,
    parameter int FS        = fft_pkg::FS,
    parameter int K_LO      = 1,
    parameter int K_HI      = 255,
    parameter int FREQ_W    = 17
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    input  logic                   in_last,
    input  logic [2*BIT_WIDTH-1:0] in_data,
    input  logic [2*BIT_WIDTH-1:0] mag_thresh,
    output logic                   out_valid,
    output logic [N-1:0]           peak_bin,
    output logic [2*BIT_WIDTH-1:0] peak_mag,
    output logic [FREQ_W-1:0]      frequency,
    output logic                   note_valid,
    output logic                   frame_err
);

    localparam int           MW     = 2 * BIT_WIDTH;
    localparam logic [N-1:0] K_LAST = N'(FFT_SIZE - 1);
    localparam logic [N-1:0] KLO    = N'(K_LO);
    localparam logic [N-1:0] KHI    = N'(K_HI);

    typedef enum logic {IDLE, ACCUM} state_t;

    state_t       state;
    logic [N-1:0] k;
    logic         tag_first, tag_end, tag_err;

    assign tag_first = (state == IDLE);
    assign tag_end   = in_last || (k == K_LAST);
    // Either in_last early or a missing in_last on the final bin.
    assign tag_err   = in_last ^ (k == K_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            k     <= '0;
        end else if (in_valid) begin
            if (tag_end) begin
                state <= IDLE;
                k     <= '0;
            end else begin
                state <= ACCUM;
                k     <= k + 1'b1;
            end
        end
    end

    logic          s1_valid, s1_first, s1_last, s1_err;
    logic [N-1:0]  s1_k;
    logic [MW-1:0] s1_mag;

    fft_mag_sq #(.BIT_WIDTH(BIT_WIDTH), .N(N)) u_mag_sq (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_first  (tag_first),
        .in_last   (tag_end),
        .in_err    (tag_err),
        .in_k      (k),
        .in_data   (in_data),
        .out_valid (s1_valid),
        .out_first (s1_first),
        .out_last  (s1_last),
        .out_err   (s1_err),
        .out_k     (s1_k),
        .out_mag   (s1_mag)
    );

    logic [MW-1:0] trk_max, base_max;
    logic [N-1:0]  trk_bin, base_bin;
    logic          upd, s2_end, s2_err;

    always_comb begin
        base_max = s1_first ? '0  : trk_max;
        base_bin = s1_first ? KLO : trk_bin;
        upd      = (s1_k >= KLO) && (s1_k <= KHI) && (s1_mag > base_max);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            trk_max <= '0;
            trk_bin <= '0;
            s2_end  <= 1'b0;
            s2_err  <= 1'b0;
        end else begin
            s2_end <= s1_valid && s1_last;
            s2_err <= s1_valid && s1_err;
            if (s1_valid) begin
                trk_max <= upd ? s1_mag : base_max;
                trk_bin <= upd ? s1_k   : base_bin;
            end
        end
    end

    logic good, thresh_ok, note_next;

    assign good      = s2_end && !s2_err;
    assign thresh_ok = (trk_max >= mag_thresh);

`ifdef PEAK_STABLE_EN
    logic [N-1:0] prev_bin, bin_diff;
    logic         prev_ok;

    always_comb begin
        bin_diff  = (trk_bin >= prev_bin) ? (trk_bin - prev_bin) : (prev_bin - trk_bin);
        note_next = thresh_ok && prev_ok && (bin_diff <= N'(1));
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev_bin <= '0;
            prev_ok  <= 1'b0;
        end else if (s2_err) begin
            prev_bin <= '0;
            prev_ok  <= 1'b0;
        end else if (good) begin
            prev_bin <= trk_bin;
            prev_ok  <= thresh_ok;
        end
    end
`else
    assign note_next = thresh_ok;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            out_valid  <= 1'b0;
            frame_err  <= 1'b0;
            peak_bin   <= '0;
            peak_mag   <= '0;
            frequency  <= '0;
            note_valid <= 1'b0;
        end else begin
            out_valid <= good;
            frame_err <= s2_err;
            if (good) begin
                peak_bin   <= trk_bin;
                peak_mag   <= trk_max;
                frequency  <= FREQ_W'(bin_to_hz(32'(trk_bin), 32'(FS), N));
                note_valid <= note_next;
            end
        end
    end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Scoreboard bench for fft_peak_detect: per-frame expectations queued at drive time.
module tb_fft_peak_detect;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_last;
    logic [31:0] in_data, mag_thresh;
    logic        out_valid, note_valid, frame_err;
    logic [8:0]  peak_bin;
    logic [31:0] peak_mag;
    logic [16:0] frequency;

    always #5 clk = ~clk;

    fft_peak_detect dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_last    (in_last),
        .in_data    (in_data),
        .mag_thresh (mag_thresh),
        .out_valid  (out_valid),
        .peak_bin   (peak_bin),
        .peak_mag   (peak_mag),
        .frequency  (frequency),
        .note_valid (note_valid),
        .frame_err  (frame_err)
    );

    int ncmp = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        ncmp++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        bit     err;
        int     bin;
        longint mag;
        int     freq;
        bit     note;
    } exp_t;

    exp_t sbq[$];

    logic signed [15:0] re[512];
    logic signed [15:0] im[512];

    int     h_bin, h_freq, p_bin;
    longint h_mag;
    bit     h_note, p_ok;

    task automatic model_reset();
        h_bin = 0; h_mag = 0; h_freq = 0; h_note = 0;
        p_ok = 0; p_bin = 0;
    endtask

    task automatic clr_frame();
        for (int i = 0; i < 512; i++) begin
            re[i] = '0;
            im[i] = '0;
        end
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_state();
        chk("rst_out_valid",  out_valid,  0);
        chk("rst_frame_err",  frame_err,  0);
        chk("rst_peak_bin",   peak_bin,   0);
        chk("rst_peak_mag",   peak_mag,   0);
        chk("rst_frequency",  frequency,  0);
        chk("rst_note_valid", note_valid, 0);
    endtask

    // Called at a negedge; drives one bin per negedge, optional idle gaps mid-frame.
    task automatic drive_frame(input int nbins, input int last_at, input bit gaps, input longint thr);
        exp_t   e;
        longint mx, m;
        int     b, d;
        bit     thr_ok;
        mag_thresh = 32'(thr);
        if (nbins == 512 && last_at == 511) begin
            mx = 0; b = 1;
            for (int i = 1; i <= 255; i++) begin
                m = longint'(re[i]) * longint'(re[i]) + longint'(im[i]) * longint'(im[i]);
                if (m > mx) begin mx = m; b = i; end
            end
            thr_ok = (mx >= thr);
            e.note = thr_ok;
`ifdef PEAK_STABLE_EN
            d = b - p_bin;
            if (d < 0) d = -d;
            e.note = thr_ok && p_ok && (d <= 1);
            p_ok  = thr_ok;
            p_bin = b;
`else
            d = 0;
`endif
            e.err = 0; e.bin = b; e.mag = mx; e.freq = (b * 48000) / 512;
            h_bin = e.bin; h_mag = e.mag; h_freq = e.freq; h_note = e.note;
            sbq.push_back(e);
        end else if (last_at >= 0 || nbins == 512) begin
            e.err = 1; e.bin = h_bin; e.mag = h_mag; e.freq = h_freq; e.note = h_note;
            p_ok = 0; p_bin = 0;
            sbq.push_back(e);
        end
        for (int i = 0; i < nbins; i++) begin
            if (gaps && (i % 50 == 25)) begin
                in_valid = 1'b0;
                in_last  = 1'b0;
                repeat (3) @(negedge clk);
            end
            in_valid = 1'b1;
            in_data  = {re[i], im[i]};
            in_last  = (i == last_at);
            @(negedge clk);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (reset === 1'b1 && (out_valid || frame_err)) begin
            if (sbq.size() == 0) begin
                chk("unexpected_output", 1, 0);
            end else begin
                e = sbq.pop_front();
                chk("frame_err",  frame_err,  e.err);
                chk("out_valid",  out_valid,  !e.err);
                chk("peak_bin",   peak_bin,   e.bin);
                chk("peak_mag",   peak_mag,   e.mag);
                chk("frequency",  frequency,  e.freq);
                chk("note_valid", note_valid, e.note);
            end
        end
    end

    initial begin
        reset = 1'b0; in_valid = 1'b0; in_last = 1'b0; in_data = '0; mag_thresh = '0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_state();
        reset = 1'b1;
        @(negedge clk);

        // Single tone at bin 20
        clr_frame(); re[20] = 1000;
        drive_frame(512, 511, 0, 1000); idle(5);

        // Tie between bins 30 and 40 keeps the lower bin
        clr_frame(); re[30] = -300; im[30] = 400; re[40] = -300; im[40] = 400;
        drive_frame(512, 511, 0, 0); idle(5);

        // Large bins outside the window are ignored; then same frame above threshold
        clr_frame(); re[0] = 32767; re[300] = 20000; re[5] = 1; im[5] = 1;
        drive_frame(512, 511, 0, 0); idle(5);
        drive_frame(512, 511, 0, 3); idle(5);

        // Window edges and worst-case magnitude
        clr_frame(); re[1] = 5; re[255] = -32768; im[255] = -32768; re[256] = -32768; im[256] = -32768;
        drive_frame(512, 511, 0, 0); idle(5);
        clr_frame(); re[1] = 5; re[256] = 30000;
        drive_frame(512, 511, 0, 30); idle(5);

        // All-zero frame
        clr_frame();
        drive_frame(512, 511, 0, 0); idle(5);

        // Early in_last, then recovery
        clr_frame(); re[20] = 1000;
        drive_frame(101, 100, 0, 0); idle(3);
        drive_frame(512, 511, 0, 0); idle(5);

        // Missing in_last, then recovery
        drive_frame(512, -1, 0, 0); idle(3);
        drive_frame(512, 511, 0, 0); idle(5);

        // Back-to-back frames with gaps, after a history-clearing error
        drive_frame(512, -1, 0, 1000); idle(3);
        clr_frame(); re[20] = 1000;
        drive_frame(512, 511, 1, 1000);
        clr_frame(); re[21] = 1000;
        drive_frame(512, 511, 1, 1000);
        clr_frame(); re[50] = 1000;
        drive_frame(512, 511, 1, 1000); idle(5);

        // Random frame
        for (int i = 0; i < 512; i++) begin
            re[i] = 16'($urandom);
            im[i] = 16'($urandom);
        end
        drive_frame(512, 511, 0, 64'($urandom_range(32'h7fff_ffff, 0))); idle(5);

        // Reset mid-frame discards the partial frame
        clr_frame(); re[100] = 30000;
        drive_frame(200, -1, 0, 0);
        in_valid = 1'b0;
        reset = 1'b0;
        model_reset();
        repeat (3) @(negedge clk);
        chk_reset_state();
        reset = 1'b1;
        @(negedge clk);
        clr_frame(); re[7] = 300; im[7] = 400;
        drive_frame(512, 511, 0, 0); idle(10);

        chk("scoreboard_drained", sbq.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule
